uart_packet_decoder: RTL and testbench
======================================

// Module: uart_packet_decoder
// PURPOSE
//  Sits between the host-link UART receiver and the programmer command engine. Hunts for the
//  DE AD BE EF sync word in the raw rx byte stream, then captures a length, command and address
//  header. Streams the payload bytes through a small FIFO with a valid/ready handshake.
// PARAMETERS
//  FIFO_DEPTH      16      payload buffer depth in bytes (power of 2, >=4)
//  TIMEOUT_CYCLES  500000  maximum idle clk cycles between bytes inside a packet before abort
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   asynchronous reset, active low
//  rx_data      in   8   byte from the UART receiver
//  rx_ready     in   1   one-cycle strobe; rx_data is valid in this cycle
//  hdr_valid    out  1   one-cycle strobe; cmd, addr and len are valid
//  cmd          out  8   command byte
//  addr         out  32  start address
//  len          out  16  payload byte count
//  pl_data      out  8   payload byte at the FIFO head
//  pl_valid     out  1   FIFO not empty
//  pl_last      out  1   pl_data is the final payload byte of the packet
//  pl_ready     in   1   consumer accepts the byte when pl_valid & pl_ready
//  busy         out  1   high in any state other than SYNC
//  err          out  1   one-cycle strobe on timeout, overflow or checksum abort
//  err_code     out  2   00 timeout, 01 FIFO overflow, 10 checksum; held until the next err
// BEHAVIOUR
//  Reset: every output is 0, the FIFO is empty and the FSM is in SYNC with sync index 0.
//  Wire format, multi-byte fields little-endian:
//    DE AD BE EF, len[7:0], len[15:8], cmd, addr[7:0] .. addr[31:24], payload x len, [csum].
//  FSM states: SYNC, LEN, CMD, ADDR, HDR, PAYLOAD, CSUM, DRAIN. The FSM advances only on rx_ready.
//  SYNC:
//   - A byte equal to the expected sync byte increments the index; the 4th match goes to LEN.
//   - A mismatching byte resets the index to 1 if the byte is DE, otherwise to 0.
//  LEN, CMD, ADDR: byte counters take 2, 1 and 4 bytes respectively, then go to HDR.
//  HDR: lasts exactly 1 cycle and pulses hdr_valid.
//   - hdr_valid rises 1 cycle after rx_ready of addr[31:24].
//   - Next state is PAYLOAD if len != 0, otherwise CSUM (macro defined) or SYNC.
//   - cmd, addr and len hold their values until the next HDR.
//  PAYLOAD: each rx byte is pushed into the FIFO together with a last flag.
//   - The last flag is set when the remaining count is 1. After the last byte, go to CSUM or DRAIN.
//  DRAIN: wait until the FIFO is empty, then go to SYNC. rx bytes received in DRAIN are ignored.
//  FIFO: first-word fall-through; a pushed byte appears on pl_data the cycle after the push.
//   - Push and pop in the same cycle are legal, including when the FIFO is full.
//  Overflow: a push into a full FIFO without a same-cycle pop drops the byte.
//   - Effect: err=1, err_code=01, the FIFO is flushed and the FSM goes to SYNC.
//  Timeout: a 32-bit idle counter is cleared on rx_ready and runs only while the state is
//   LEN..CSUM (excluding HDR and DRAIN).
//   - At TIMEOUT_CYCLES: err=1, err_code=00, FSM goes to SYNC.
//   - The FIFO is NOT flushed, so bytes already queued still drain. pl_last never asserts
//     for an aborted packet.
//  reset_n asserted mid-packet: immediate return to the reset state; any partial packet is lost.
// CONFIGURATION
//  PKT_CHECKSUM_EN defined: one trailing byte follows the payload, CSUM state is used.
//   - Required value: 8-bit sum of all bytes from len[7:0] through the last payload byte,
//     modulo 256, equal to the received csum byte.
//   - On mismatch: err=1, err_code=10, FIFO flushed, FSM goes to SYNC. On match: go to DRAIN.
//   - With a checksum, pl_valid is withheld for the entire packet until the checksum passes;
//     the FIFO still fills. Packets longer than FIFO_DEPTH then overflow.
//  PKT_CHECKSUM_EN undefined: no CSUM state; the byte after the payload is treated as a SYNC
//   candidate; pl_valid follows the FIFO not-empty status directly.
// STRUCTURE
//  Shared package: state encoding constants, sync bytes 8'hDE/8'hAD/8'hBE/8'hEF, err_code values.
//  Sub-module byte_fifo (parameter DEPTH, 9-bit entries = {last,data}):
//   - ports: push, pop, flush, full, empty.
//   - the decoder holds the FSM, counters and header registers.
// TESTING
//  1 Send DE AD BE EF 0E 02 01 00 01 00 00 with pl_ready=1.
//    -> hdr_valid once, len=16'h020E, cmd=8'h01, addr=32'h00000100, busy stays 1.
//  2 Send DE DE AD BE EF 03 00 05 10 00 00 00 72 67 20 with pl_ready=1.
//    -> header accepted; pl_data 72, 67, 20 in order; pl_last only on 20; busy=0 after drain.
//  3 Same as 2 with pl_ready=0 for 40 cycles.
//    -> bytes held in order, no loss; pl_last still only on 20.
//  4 Send FIFO_DEPTH+1 payload bytes with pl_ready=0.
//    -> err pulse, err_code=01, pl_valid=0, FSM returns to SYNC.
//  5 Send header of a 4-byte packet, 2 payload bytes, then idle TIMEOUT_CYCLES.
//    -> err pulse, err_code=00; the 2 queued bytes still drain with pl_last=0.
//  6 PKT_CHECKSUM_EN defined: send a 1-byte packet with a wrong csum, then the same packet
//    with the correct csum.
//    -> first packet: err_code=10, pl_valid never 1; second packet: byte delivered with pl_last=1.

Source files
------------

// File: rtl/uart_packet_decoder_pkg.sv
// Shared definitions for the host-link packet decoder: FSM states, sync word bytes, error codes.
package uart_packet_decoder_pkg;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_LEN,
    ST_CMD,
    ST_ADDR,
    ST_HDR,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DRAIN
  } state_t;

  localparam logic [7:0] SYNC_B0 = 8'hDE;
  localparam logic [7:0] SYNC_B1 = 8'hAD;
  localparam logic [7:0] SYNC_B2 = 8'hBE;
  localparam logic [7:0] SYNC_B3 = 8'hEF;

  localparam logic [1:0] ERR_TIMEOUT  = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW = 2'b01;
  localparam logic [1:0] ERR_CHECKSUM = 2'b10;

  function automatic logic [7:0] sync_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return SYNC_B0;
      2'd1:    return SYNC_B1;
      2'd2:    return SYNC_B2;
      default: return SYNC_B3;
    endcase
  endfunction

endpackage

// File: rtl/uart_packet_decoder_byte_fifo.sv
// First-word fall-through payload FIFO, 9-bit entries {last, data}; push and pop may
// coincide even when full, and a push into a full FIFO without a pop is dropped.
module byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [8:0] wdata,
  output logic [8:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [8:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_packet_decoder.sv
// Host-link packet decoder: sync hunt, header capture, payload FIFO streaming.
// Optional trailing checksum byte enabled by defining PKT_CHECKSUM_EN.
module uart_packet_decoder
  import uart_packet_decoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        hdr_valid,
  output logic [7:0]  cmd,
  output logic [31:0] addr,
  output logic [15:0] len,
  output logic [7:0]  pl_data,
  output logic        pl_valid,
  output logic        pl_last,
  input  logic        pl_ready,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_code
);

  state_t      state;
  logic [1:0]  sync_idx;
  logic [1:0]  byte_idx;
  logic [15:0] len_sh;
  logic [7:0]  cmd_sh;
  logic [23:0] addr_sh;
  logic [15:0] rem;
  logic [31:0] idle_cnt;

  logic        push;
  logic        pop;
  logic        flush;
  logic        overflow;
  logic        csum_bad;
  logic        counting;
  logic        timeout_hit;
  logic        fifo_full;
  logic        fifo_empty;
  logic [8:0]  fifo_head;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wdata   ({rem == 16'd1, rx_data}),
    .rdata   (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef PKT_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum <= '0;
    end else if (state == ST_SYNC) begin
      csum <= '0;
    end else if (rx_ready && (state inside {ST_LEN, ST_CMD, ST_ADDR, ST_PAYLOAD})) begin
      csum <= csum + rx_data;
    end
  end

  // Payload stays hidden until its checksum has been accepted (DRAIN) or the packet is gone (SYNC).
  assign pl_valid = !fifo_empty && (state == ST_SYNC || state == ST_DRAIN);
  assign csum_bad = (state == ST_CSUM) && rx_ready && (rx_data != csum);
`else
  assign pl_valid = !fifo_empty;
  assign csum_bad = 1'b0;
`endif

  assign pl_data     = fifo_empty ? '0 : fifo_head[7:0];
  assign pl_last     = pl_valid && fifo_head[8];
  assign busy        = (state != ST_SYNC);
  assign pop         = pl_valid && pl_ready;
  assign push        = (state == ST_PAYLOAD) && rx_ready;
  assign overflow    = push && fifo_full && !pop;
  assign flush       = overflow || csum_bad;
  assign counting    = state inside {ST_LEN, ST_CMD, ST_ADDR, ST_PAYLOAD, ST_CSUM};
  assign timeout_hit = counting && !rx_ready && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_SYNC;
      sync_idx  <= '0;
      byte_idx  <= '0;
      len_sh    <= '0;
      cmd_sh    <= '0;
      addr_sh   <= '0;
      rem       <= '0;
      idle_cnt  <= '0;
      hdr_valid <= 1'b0;
      cmd       <= '0;
      addr      <= '0;
      len       <= '0;
      err       <= 1'b0;
      err_code  <= '0;
    end else begin
      hdr_valid <= 1'b0;
      err       <= 1'b0;

      if (rx_ready || !counting) idle_cnt <= '0;
      else                       idle_cnt <= idle_cnt + 32'd1;

      if (timeout_hit) begin
        err      <= 1'b1;
        err_code <= ERR_TIMEOUT;
        state    <= ST_SYNC;
        sync_idx <= '0;
      end else if (flush) begin
        err      <= 1'b1;
        err_code <= overflow ? ERR_OVERFLOW : ERR_CHECKSUM;
        state    <= ST_SYNC;
        sync_idx <= '0;
      end else begin
        case (state)
          ST_SYNC: begin
            if (rx_ready) begin
              if (rx_data == sync_byte(sync_idx)) begin
                if (sync_idx == 2'd3) begin
                  state    <= ST_LEN;
                  sync_idx <= '0;
                  byte_idx <= '0;
                end else begin
                  sync_idx <= sync_idx + 2'd1;
                end
              end else begin
                sync_idx <= (rx_data == SYNC_B0) ? 2'd1 : 2'd0;
              end
            end
          end
          ST_LEN: begin
            if (rx_ready) begin
              len_sh <= {rx_data, len_sh[15:8]};
              if (byte_idx == 2'd1) begin
                byte_idx <= '0;
                state    <= ST_CMD;
              end else begin
                byte_idx <= byte_idx + 2'd1;
              end
            end
          end
          ST_CMD: begin
            if (rx_ready) begin
              cmd_sh <= rx_data;
              state  <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            if (rx_ready) begin
              addr_sh <= {rx_data, addr_sh[23:8]};
              if (byte_idx == 2'd3) begin
                byte_idx  <= '0;
                state     <= ST_HDR;
                hdr_valid <= 1'b1;
                cmd       <= cmd_sh;
                len       <= len_sh;
                addr      <= {rx_data, addr_sh};
              end else begin
                byte_idx <= byte_idx + 2'd1;
              end
            end
          end
          ST_HDR: begin
            rem <= len;
            if (len != 16'd0) state <= ST_PAYLOAD;
`ifdef PKT_CHECKSUM_EN
            else              state <= ST_CSUM;
`else
            else              state <= ST_SYNC;
`endif
          end
          ST_PAYLOAD: begin
            if (rx_ready) begin
              rem <= rem - 16'd1;
`ifdef PKT_CHECKSUM_EN
              if (rem == 16'd1) state <= ST_CSUM;
`else
              if (rem == 16'd1) state <= ST_DRAIN;
`endif
            end
          end
`ifdef PKT_CHECKSUM_EN
          ST_CSUM: begin
            if (rx_ready) state <= ST_DRAIN;
          end
`endif
          ST_DRAIN: begin
            if (fifo_empty) state <= ST_SYNC;
          end
          default: state <= ST_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_packet_decoder.sv
// Scoreboard bench for uart_packet_decoder; also covers the checksum path when PKT_CHECKSUM_EN is defined.
module tb_uart_packet_decoder;

  localparam int unsigned FD = 16;
  localparam int unsigned TO = 200;
`ifdef PKT_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        hdr_valid;
  logic [7:0]  cmd;
  logic [31:0] addr;
  logic [15:0] len;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_last;
  logic        pl_ready;
  logic        busy;
  logic        err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  uart_packet_decoder #(.FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .hdr_valid (hdr_valid),
    .cmd       (cmd),
    .addr      (addr),
    .len       (len),
    .pl_data   (pl_data),
    .pl_valid  (pl_valid),
    .pl_last   (pl_last),
    .pl_ready  (pl_ready),
    .busy      (busy),
    .err       (err),
    .err_code  (err_code)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [15:0] len;
  } hdr_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } pl_t;

  hdr_t       exp_hdr[$];
  pl_t        exp_pl[$];
  logic [1:0] exp_err[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  pl_buf [32];
  bit          pv_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every DUT output event consumes one queued expectation.
  hdr_t       mh;
  pl_t        mp;
  logic [1:0] me;
  always @(negedge clk) begin
    if (reset_n) begin
      if (pl_valid) pv_seen = 1'b1;
      if (hdr_valid) begin
        if (exp_hdr.size() == 0) check("hdr_extra", 1, 0);
        else begin
          mh = exp_hdr.pop_front();
          check("hdr_cmd", cmd, mh.cmd);
          check("hdr_addr", addr, mh.addr);
          check("hdr_len", len, mh.len);
        end
      end
      if (err) begin
        if (exp_err.size() == 0) check("err_extra", 1, 0);
        else begin
          me = exp_err.pop_front();
          check("err_code", err_code, me);
        end
      end
      if (pl_valid && pl_ready) begin
        if (exp_pl.size() == 0) check("pl_extra", {pl_last, pl_data}, 0);
        else begin
          mp = exp_pl.pop_front();
          check("pl_data", pl_data, mp.d);
          check("pl_last", pl_last, mp.l);
        end
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] c, input logic [31:0] a, input logic [15:0] l,
                             input int unsigned n, input bit with_csum, input logic [7:0] csum_xor,
                             input bit tail_idle);
    logic [7:0] s;
    logic [7:0] hb [7];
    hb = '{l[7:0], l[15:8], c, a[7:0], a[15:8], a[23:16], a[31:24]};
    s  = '0;
    send_byte(8'hDE); tick(2);
    send_byte(8'hAD); tick(2);
    send_byte(8'hBE); tick(2);
    send_byte(8'hEF); tick(2);
    for (int i = 0; i < 7; i++) begin
      s = s + hb[i];
      send_byte(hb[i]);
      if (tail_idle || i < 6 || n != 0 || with_csum) tick(2);
    end
    for (int i = 0; i < int'(n); i++) begin
      s = s + pl_buf[i];
      send_byte(pl_buf[i]);
      if (tail_idle || i < int'(n) - 1 || with_csum) tick(2);
    end
    if (with_csum) begin
      send_byte(s ^ csum_xor);
      if (tail_idle) tick(2);
    end
  endtask

  task automatic expect_payload(input int unsigned n);
    for (int i = 0; i < int'(n); i++) exp_pl.push_back('{pl_buf[i], (i == int'(n) - 1)});
  endtask

  task automatic wait_idle(input string tag, input int unsigned max);
    int unsigned n = 0;
    while ((busy || pl_valid) && n < max) begin
      tick(1);
      n++;
    end
    check(tag, {busy, pl_valid}, 2'b00);
  endtask

  task automatic check_queues(input string tag);
    check({tag, "_hdrq"}, exp_hdr.size(), 0);
    check({tag, "_plq"}, exp_pl.size(), 0);
    check({tag, "_errq"}, exp_err.size(), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n  = 1'b0;
    rx_data  = '0;
    rx_ready = 1'b0;
    pl_ready = 1'b1;
    pv_seen  = 1'b0;
    tick(3);
    check("rst_hdr_valid", hdr_valid, 0);
    check("rst_cmd", cmd, 0);
    check("rst_addr", addr, 0);
    check("rst_len", len, 0);
    check("rst_pl_valid", pl_valid, 0);
    check("rst_pl_last", pl_last, 0);
    check("rst_pl_data", pl_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    reset_n = 1'b1;
    tick(2);

    // 1: header only, hdr_valid one cycle after the last address byte
    exp_hdr.push_back('{8'h01, 32'h0000_0100, 16'h020E});
    send_packet(8'h01, 32'h0000_0100, 16'h020E, 0, 1'b0, 8'h00, 1'b0);
    check("t1_hdr_latency", hdr_valid, 1);
    tick(4);
    check("t1_busy", busy, 1);
    reset_n = 1'b0;
    tick(2);
    check("t1_rst_busy", busy, 0);
    check("t1_rst_len", len, 0);
    reset_n = 1'b1;
    tick(2);
    check_queues("t1");

    // 2: leading extra DE, 3-byte payload streamed straight out
    pl_buf[0] = 8'h72; pl_buf[1] = 8'h67; pl_buf[2] = 8'h20;
    exp_hdr.push_back('{8'h05, 32'h0000_0010, 16'h0003});
    expect_payload(3);
    send_byte(8'hDE); tick(2);
    send_packet(8'h05, 32'h0000_0010, 16'h0003, 3, CSUM_ON, 8'h00, 1'b1);
    wait_idle("t2_drain", 50);
    check_queues("t2");

    // 3: same packet with the consumer stalled
    pl_ready = 1'b0;
    exp_hdr.push_back('{8'h05, 32'h0000_0010, 16'h0003});
    expect_payload(3);
    send_packet(8'h05, 32'h0000_0010, 16'h0003, 3, CSUM_ON, 8'h00, 1'b1);
    tick(40);
    check("t3_held_valid", pl_valid, 1);
    check("t3_held_data", pl_data, 8'h72);
    check("t3_held_last", pl_last, 0);
    check("t3_busy", busy, 1);
    pl_ready = 1'b1;
    wait_idle("t3_drain", 50);
    check_queues("t3");

    // 4: FIFO_DEPTH+1 payload bytes into a stalled consumer
    pl_ready = 1'b0;
    for (int i = 0; i <= int'(FD); i++) pl_buf[i] = 8'(8'h80 + i);
    exp_hdr.push_back('{8'h30, 32'h0000_1000, 16'(FD + 1)});
    exp_err.push_back(2'b01);
    send_packet(8'h30, 32'h0000_1000, 16'(FD + 1), FD + 1, 1'b0, 8'h00, 1'b0);
    check("t4_err", err, 1);
    tick(2);
    check("t4_err_code", err_code, 2'b01);
    check("t4_pl_valid", pl_valid, 0);
    check("t4_busy", busy, 0);
    pl_ready = 1'b1;
    tick(2);
    check_queues("t4");

    // 5: 4-byte packet aborted by idle timeout after 2 payload bytes
    pl_ready = 1'b0;
    pl_buf[0] = 8'hAA; pl_buf[1] = 8'hBB;
    exp_hdr.push_back('{8'h40, 32'h0000_2000, 16'h0004});
    exp_err.push_back(2'b00);
    exp_pl.push_back('{8'hAA, 1'b0});
    exp_pl.push_back('{8'hBB, 1'b0});
    send_packet(8'h40, 32'h0000_2000, 16'h0004, 2, 1'b0, 8'h00, 1'b0);
    tick(TO - 1);
    check("t5_tmo_early", err, 0);
    tick(1);
    check("t5_tmo_edge", err, 1);
    check("t5_tmo_code", err_code, 2'b00);
    tick(1);
    check("t5_busy", busy, 0);
    check("t5_queued_valid", pl_valid, 1);
    check("t5_queued_last", pl_last, 0);
    pl_ready = 1'b1;
    wait_idle("t5_drain", 20);
    check_queues("t5");

`ifdef PKT_CHECKSUM_EN
    // 6: bad checksum then good checksum for the same 1-byte packet
    pl_buf[0] = 8'h5A;
    pv_seen   = 1'b0;
    exp_hdr.push_back('{8'h22, 32'h0000_0040, 16'h0001});
    exp_err.push_back(2'b10);
    send_packet(8'h22, 32'h0000_0040, 16'h0001, 1, 1'b1, 8'hFF, 1'b1);
    tick(3);
    check("t6_bad_code", err_code, 2'b10);
    check("t6_bad_never_valid", pv_seen, 0);
    check("t6_bad_busy", busy, 0);
    exp_hdr.push_back('{8'h22, 32'h0000_0040, 16'h0001});
    expect_payload(1);
    send_packet(8'h22, 32'h0000_0040, 16'h0001, 1, 1'b1, 8'h00, 1'b1);
    wait_idle("t6_drain", 20);
    check_queues("t6");
`endif

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
